spi_dac_receiver: RTL and testbench

SPI responder for the MCP4921 DAC link driven by spi2dac. It models the DAC end of the link: it oversamples dac_cs, dac_sck and dac_sdi on sysclk and shifts in 16-bit MSB-first frames. On each CS deassertion it either publishes the decoded control nibble and 12-bit code with a one-cycle valid pulse, or flags a framing error. It serves as the bench/loopback checker for the DAC path, and as the receive front-end when a second board listens to the DAC bus.

---
 rtl/spi_dac_receiver.sv | 180 ++++++++++++++++++
 tb/tb_spi_dac_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_receiver.sv
// spi_dac_receiver: DAC-side SPI responder for the MCP4921 link.
// Oversamples dac_cs/dac_sck/dac_sdi on sysclk and shifts in MSB-first
// frames. When chip select rises, a frame of exactly FRAME_BITS bits
// publishes ctrl/dac_code with a one-cycle data_valid pulse. A frame of
// any other length raises a one-cycle frame_err pulse instead.
// Ports:
//   sysclk, rst_n        system clock, async active-low reset
//   dac_cs/sck/sdi       SPI bus, asynchronous to sysclk
//   ctrl[3:0]            frame bits [15:12] {A/B, BUF, GA_n, SHDN_n}
//   dac_code[11:0]       frame bits [11:0]
//   data_valid           one-cycle pulse when ctrl/dac_code update
//   frame_err            one-cycle pulse on a wrong-length frame
//   busy                 high while a frame is being shifted in
//   frame_count[15:0]    good frames received, wraps
module spi_dac_receiver #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        dac_cs,
  input  logic        dac_sck,
  input  logic        dac_sdi,
  output logic [3:0]  ctrl,
  output logic [11:0] dac_code,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Synchronisers plus one extra delayed copy of cs and sck for edge detection
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   cs_dly_q, cs_dly_d;
  logic                   sck_dly_q, sck_dly_d;

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             ctrl_q, ctrl_d;
  logic [11:0]            code_q, code_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [15:0]            fcount_q, fcount_d;

  logic cs_s, sck_s, sdi_s;
  logic cs_rise_c, cs_fall_c, sck_rise_c;

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  assign cs_rise_c  = cs_s & ~cs_dly_q;
  assign cs_fall_c  = ~cs_s & cs_dly_q;
  assign sck_rise_c = sck_s & ~sck_dly_q;

  // Synchroniser shift paths
  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], dac_cs};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], dac_sck};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], dac_sdi};
    cs_dly_d   = cs_s;
    sck_dly_d  = sck_s;
  end

  // Frame FSM and output update logic
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    busy_d   = busy_q;
    fcount_d = fcount_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall_c) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        // cs rising takes priority over a coincident sck rising edge
        if (cs_rise_c) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else if (sck_rise_c) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (cnt_q == CNT_FULL) begin
          ctrl_d   = shift_q[FRAME_BITS-1 -: 4];
          code_d   = shift_q[11:0];
          valid_d  = 1'b1;
          fcount_d = fcount_q + 16'd1;
        end else begin
          err_d = 1'b1;
        end
        // A new frame may already be starting; do not lose its cs edge
        if (cs_fall_c) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronisers reset to the idle bus
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_dly_q   <= 1'b1;
      sck_dly_q  <= 1'b0;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      fcount_q   <= '0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      cs_dly_q   <= cs_dly_d;
      sck_dly_q  <= sck_dly_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      fcount_q   <= fcount_d;
    end
  end

  assign ctrl        = ctrl_q;
  assign dac_code    = code_q;
  assign data_valid  = valid_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Scoreboard bench for spi_dac_receiver: stimulus pushes the expected
// response of every frame; a monitor pops and compares on each pulse.
module tb_spi_dac_receiver;

  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned SYNC_STAGES = 2;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        dac_cs, dac_sck, dac_sdi;
  logic [3:0]  ctrl;
  logic [11:0] dac_code;
  logic        data_valid, frame_err, busy;
  logic [15:0] frame_count;

  spi_dac_receiver #(.FRAME_BITS(FRAME_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .dac_cs      (dac_cs),
    .dac_sck     (dac_sck),
    .dac_sdi     (dac_sdi),
    .ctrl        (ctrl),
    .dac_code    (dac_code),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #10 sysclk = ~sysclk;

  typedef struct {
    bit          is_err;
    logic [3:0]  ctrl;
    logic [11:0] code;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;

  // Reference model state: last good word and good-frame count
  logic [3:0]  m_ctrl;
  logic [11:0] m_code;
  logic [15:0] m_cnt;

  always @(posedge sysclk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic model_reset();
    m_ctrl = '0;
    m_code = '0;
    m_cnt  = '0;
  endtask

  // A frame of exactly FRAME_BITS bits decodes; anything else is an error
  task automatic model_frame(input int nbits, input logic [31:0] bits, input int cyc);
    exp_t e;
    if (nbits == FRAME_BITS) begin
      m_ctrl = bits[15:12];
      m_code = bits[11:0];
      m_cnt  = m_cnt + 16'd1;
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.ctrl = m_ctrl;
    e.code = m_code;
    e.cnt  = m_cnt;
    e.cyc  = cyc;
    sb_q.push_back(e);
  endtask

  task automatic clock_bit(input logic b, input int half);
    dac_sdi = b;
    wait_cycles(half);
    dac_sck = 1'b1;
    wait_cycles(half);
    dac_sck = 1'b0;
  endtask

  task automatic send_frame(input int nbits, input logic [31:0] bits, input int gap);
    int half;
    half = int'($urandom_range(3, 6));
    dac_cs = 1'b0;
    wait_cycles(half + 2);
    for (int i = nbits - 1; i >= 0; i--) clock_bit(bits[i], half);
    wait_cycles(half);
    check("busy_in_frame", busy, 1);
    dac_cs = 1'b1;
    model_frame(nbits, bits, cycle + SYNC_STAGES + 2);
    wait_cycles(gap);
    check("busy_after_frame", busy, 0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    dac_cs  = 1'b1;
    dac_sck = 1'b0;
    dac_sdi = 1'b0;
    wait_cycles(3);
    model_reset();
    rst_n = 1'b1;
    wait_cycles(3);
  endtask

  task automatic check_reset_state();
    check("rst_ctrl", ctrl, 0);
    check("rst_code", dac_code, 0);
    check("rst_valid", data_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_count", frame_count, 0);
  endtask

  // Monitor: every pulse must match the oldest expected response
  always @(negedge sysclk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (data_valid || frame_err) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b err=%0b with nothing expected at cycle %0d",
                   data_valid, frame_err, cycle);
        end else begin
          e = sb_q.pop_front();
          check("pulse_valid", data_valid, {31'd0, !e.is_err});
          check("pulse_err", frame_err, {31'd0, e.is_err});
          check("ctrl", ctrl, e.ctrl);
          check("dac_code", dac_code, e.code);
          check("frame_count", frame_count, e.cnt);
          check("latency", cycle, e.cyc);
        end
      end else if (sb_q.size() > 0 && cycle > sb_q[0].cyc) begin
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: expected err=%0b by cycle %0d", e.is_err, e.cyc);
      end
    end
  end

  initial begin
    logic [31:0] w;
    int          n;
    do_reset();
    check_reset_state();

    // Basic decode
    send_frame(16, 32'h3ABC, 10);
    check("basic_ctrl", ctrl, 4'h3);
    check("basic_code", dac_code, 12'hABC);
    check("basic_count", frame_count, 1);

    // Short and long frames must error and leave outputs alone
    send_frame(10, 32'($urandom), 10);
    send_frame(17, 32'($urandom), 10);
    send_frame(0, 32'd0, 10);
    check("len_ctrl_hold", ctrl, 4'h3);
    check("len_code_hold", dac_code, 12'hABC);
    check("len_count_hold", frame_count, 1);

    // sck activity with cs high is ignored
    for (int i = 0; i < 20; i++) begin
      dac_sdi = 1'($urandom);
      dac_sck = 1'b1;
      wait_cycles(3);
      dac_sck = 1'b0;
      wait_cycles(3);
    end
    send_frame(16, 32'h7001, 10);
    check("idle_sck_ctrl", ctrl, 4'h7);
    check("idle_sck_code", dac_code, 12'h001);

    // Reset in the middle of a frame discards it
    dac_cs = 1'b0;
    wait_cycles(6);
    for (int i = 0; i < 8; i++) clock_bit(1'($urandom), 4);
    do_reset();
    check_reset_state();
    send_frame(16, 32'h3FFF, 10);
    check("abort_code", dac_code, 12'hFFF);
    check("abort_count", frame_count, 1);

    // Back-to-back frames with a short cs-high gap
    do_reset();
    send_frame(16, 32'h3000, 4);
    send_frame(16, 32'h3FFF, 10);
    check("b2b_code", dac_code, 12'hFFF);
    check("b2b_count", frame_count, 2);

    // Loopback-style frames: {4'h3, 10-bit data, 2'b00}
    do_reset();
    for (int i = 0; i < 100; i++) begin
      w = {16'd0, 4'h3, 10'($urandom_range(0, 1023)), 2'b00};
      send_frame(16, w, int'($urandom_range(4, 8)));
    end
    check("loop_count", frame_count, 100);
    check("loop_ctrl", ctrl, 4'h3);

    // Random lengths and contents
    for (int i = 0; i < 30; i++) begin
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 16;
      send_frame(n, 32'($urandom), int'($urandom_range(4, 8)));
    end

    wait_cycles(20);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
